// File: rtl/otter_pkg.sv
// Shared types for the OTTER decode stage: opcodes, ALU codes, mux selects
// and the registered control bundle carried from ID to EX.
package otter_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_STORE  = 7'b0100011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [31:0] MRET_INSTR = 32'h3020_0073;

    typedef enum logic [1:0] {SRCA_RS1 = 2'd0, SRCA_UIMM = 2'd1, SRCA_NOT_RS1 = 2'd2} srca_t;
    typedef enum logic [2:0] {SRCB_RS2 = 3'd0, SRCB_IIMM = 3'd1, SRCB_SIMM = 3'd2,
                              SRCB_PC = 3'd3, SRCB_CSR = 3'd4} srcb_t;
    typedef enum logic [1:0] {WR_PC4 = 2'd0, WR_CSR = 2'd1, WR_MEM = 2'd2, WR_ALU = 2'd3} wrsel_t;
    typedef enum logic [2:0] {BR_EQ = 3'b000, BR_NE = 3'b001, BR_NONE = 3'b010, BR_LT = 3'b100,
                              BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111} br_t;
    typedef enum logic [1:0] {JMP_NONE = 2'd0, JMP_JALR = 2'd1, JMP_JAL = 2'd2} jump_t;
    typedef enum logic [1:0] {CSR_NONE = 2'd0, CSR_RW = 2'd1, CSR_RS = 2'd2, CSR_RC = 2'd3} csr_op_t;

    typedef struct packed {
        logic [3:0] alu_fun;
        srca_t      alu_srcA;
        srcb_t      alu_srcB;
        wrsel_t     rf_wr_sel;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        br_t        br_type;
        jump_t      jump;
        csr_op_t    csr_op;
        logic       mret;
        logic       trap;
        logic       illegal;
        logic [2:0] mext;
        logic       is_mext;
    } ctrl_t;

    // A bundle that does nothing: no writes, no memory, no branch.
    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c = '0;
        c.br_type = BR_NONE;
        return c;
    endfunction

endpackage

// File: rtl/otter_ctrl_dcdr.sv
// Combinational instruction decoder: instruction word -> control bundle plus
// flags telling the hazard logic which source registers are actually read.
module otter_ctrl_dcdr
    import otter_pkg::*;
#(
    parameter bit SUPPORT_MEXT = 1'b0
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        rs1_used_o,
    output logic        rs2_used_o
);

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       writes_rd;

    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd     = instr_i[11:7];

    // Decode by opcode; illegal encodings are scrubbed at the end.
    always_comb begin
        ctrl_o     = idle_ctrl();
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        writes_rd  = 1'b0;
        case (instr_i[6:0])
            OPC_LOAD: begin
                ctrl_o.alu_srcB  = SRCB_IIMM;
                ctrl_o.rf_wr_sel = WR_MEM;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.mem_size  = funct3;
                rs1_used_o       = 1'b1;
                writes_rd        = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.alu_srcB  = SRCB_SIMM;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.mem_size  = funct3;
                rs1_used_o       = 1'b1;
                rs2_used_o       = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only the right shift uses funct7[5] (srai); other I-type bits are immediate.
                ctrl_o.alu_fun   = {(funct3 == 3'b101) & funct7[5], funct3};
                ctrl_o.alu_srcB  = SRCB_IIMM;
                ctrl_o.rf_wr_sel = WR_ALU;
                rs1_used_o       = 1'b1;
                writes_rd        = 1'b1;
            end
            OPC_OP: begin
                rs1_used_o       = 1'b1;
                rs2_used_o       = 1'b1;
                ctrl_o.rf_wr_sel = WR_ALU;
                writes_rd        = 1'b1;
                if (funct7 == 7'b0000001) begin
                    if (SUPPORT_MEXT) begin
                        ctrl_o.is_mext = 1'b1;
                        ctrl_o.mext    = funct3;
                    end else begin
                        ctrl_o.illegal = 1'b1;
                    end
                end else begin
                    ctrl_o.alu_fun = {funct7[5], funct3};
                end
            end
            OPC_LUI: begin
                ctrl_o.alu_fun   = ALU_LUI;
                ctrl_o.alu_srcA  = SRCA_UIMM;
                ctrl_o.rf_wr_sel = WR_ALU;
                writes_rd        = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_o.alu_srcA  = SRCA_UIMM;
                ctrl_o.alu_srcB  = SRCB_PC;
                ctrl_o.rf_wr_sel = WR_ALU;
                writes_rd        = 1'b1;
            end
            OPC_JAL: begin
                ctrl_o.jump      = JMP_JAL;
                ctrl_o.rf_wr_sel = WR_PC4;
                writes_rd        = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.jump      = JMP_JALR;
                ctrl_o.alu_srcB  = SRCB_IIMM;
                ctrl_o.rf_wr_sel = WR_PC4;
                rs1_used_o       = 1'b1;
                writes_rd        = 1'b1;
            end
            OPC_BRANCH: begin
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b1;
                if (funct3 == 3'b010 || funct3 == 3'b011) ctrl_o.illegal = 1'b1;
                else                                      ctrl_o.br_type = br_t'(funct3);
            end
            OPC_SYSTEM: begin
                ctrl_o.rf_wr_sel = WR_CSR;
                case (funct3)
                    3'b000: begin
                        ctrl_o.rf_wr_sel = WR_PC4;
                        if (instr_i == MRET_INSTR) ctrl_o.mret    = 1'b1;
                        else                       ctrl_o.illegal = 1'b1;
                    end
                    3'b001: begin
                        ctrl_o.csr_op = CSR_RW;
                        ctrl_o.alu_fun = ALU_LUI;
                        rs1_used_o = 1'b1;
                        writes_rd  = 1'b1;
                    end
                    3'b010: begin
                        ctrl_o.csr_op   = CSR_RS;
                        ctrl_o.alu_fun  = ALU_OR;
                        ctrl_o.alu_srcB = SRCB_CSR;
                        rs1_used_o = 1'b1;
                        writes_rd  = 1'b1;
                    end
                    3'b011: begin
                        ctrl_o.csr_op   = CSR_RC;
                        ctrl_o.alu_fun  = ALU_AND;
                        ctrl_o.alu_srcA = SRCA_NOT_RS1;
                        ctrl_o.alu_srcB = SRCB_CSR;
                        rs1_used_o = 1'b1;
                        writes_rd  = 1'b1;
                    end
                    default: ctrl_o.illegal = 1'b1;
                endcase
            end
            default: ctrl_o.illegal = 1'b1;
        endcase

        // An illegal op carries nothing but its illegal flag into EX.
        if (ctrl_o.illegal) begin
            ctrl_o         = idle_ctrl();
            ctrl_o.illegal = 1'b1;
            rs1_used_o     = 1'b0;
            rs2_used_o     = 1'b0;
            writes_rd      = 1'b0;
        end
        ctrl_o.reg_write = writes_rd & (rd != 5'd0);
    end

endmodule

// File: rtl/otter_decode_stage.sv
// ID stage: decodes the fetched instruction into the ID/EX register, inserting
// load-use bubbles, honouring EX backpressure, flushes and interrupt traps.
// Handshake: an instruction moves from IF to ID/EX on a rising edge where
// if_valid & id_ready & !flush; the ID/EX contents move on when ex_ready is high.
module otter_decode_stage
    import otter_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit SUPPORT_MEXT   = 1'b0,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            ex_ready,
    input  logic            flush,
    input  logic            int_taken,
    output logic            ex_valid,
    output ctrl_t           ex_ctrl,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [15:0]     stall_cnt
);

    ctrl_t           dec_ctrl;
    logic            rs1_used, rs2_used;
    logic [4:0]      if_rs1, if_rs2, if_rd;
    logic            hz;

    logic            ex_valid_q, ex_valid_d;
    ctrl_t           ex_ctrl_q, ex_ctrl_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [4:0]      ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    otter_ctrl_dcdr #(.SUPPORT_MEXT(SUPPORT_MEXT)) u_dcdr (
        .instr_i    (if_instr),
        .ctrl_o     (dec_ctrl),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    assign if_rs1 = if_instr[19:15];
    assign if_rs2 = if_instr[24:20];
    assign if_rd  = if_instr[11:7];

    // A load in EX whose destination feeds the instruction at IF forces a bubble.
    assign hz = LOAD_USE_STALL && ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != 5'd0) &&
                (((ex_rd_q == if_rs1) && rs1_used) || ((ex_rd_q == if_rs2) && rs2_used));

    assign id_ready = !RST && ex_ready && !hz;

    // Next-state for the ID/EX register, in priority order flush > hold > bubble > load.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_pc_d     = ex_pc_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_rd_d     = ex_rd_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (ex_ready) begin
            if (hz) begin
                ex_valid_d = 1'b0;
                if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
            end else if (if_valid) begin
                ex_valid_d = 1'b1;
                ex_pc_d    = if_pc;
                if (int_taken) begin
                    // The trap replaces the instruction; it names no registers.
                    ex_ctrl_d      = idle_ctrl();
                    ex_ctrl_d.trap = 1'b1;
                    ex_rs1_d       = 5'd0;
                    ex_rs2_d       = 5'd0;
                    ex_rd_d        = 5'd0;
                end else begin
                    ex_ctrl_d = dec_ctrl;
                    ex_rs1_d  = if_rs1;
                    ex_rs2_d  = if_rs2;
                    ex_rd_d   = if_rd;
                end
            end else begin
                ex_valid_d = 1'b0;
            end
        end
    end

    // ID/EX register and bubble counter with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_pc_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_pc_q     <= ex_pc_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign ex_pc     = ex_pc_q;
    assign ex_rs1    = ex_rs1_q;
    assign ex_rs2    = ex_rs2_q;
    assign ex_rd     = ex_rd_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_otter_decode_stage.sv
// Bench for otter_decode_stage. Instance 0: SUPPORT_MEXT=0, LOAD_USE_STALL=1;
// instance 1: SUPPORT_MEXT=1, LOAD_USE_STALL=0. Both see identical inputs.
module tb_otter_decode_stage;
    import otter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        ex_ready = 1'b1;
    logic        flush = 1'b0;
    logic        int_taken = 1'b0;

    logic        id_ready [2];
    logic        ex_valid [2];
    ctrl_t       ex_ctrl [2];
    logic [31:0] ex_pc [2];
    logic [4:0]  ex_rs1 [2];
    logic [4:0]  ex_rs2 [2];
    logic [4:0]  ex_rd [2];
    logic [15:0] stall_cnt [2];

    // reference model state per instance
    bit          sup [2] = '{1'b0, 1'b1};
    bit          lus [2] = '{1'b1, 1'b0};
    bit          mv [2];
    ctrl_t       mc [2];
    logic [31:0] mpc [2];
    logic [4:0]  mr1 [2];
    logic [4:0]  mr2 [2];
    logic [4:0]  mrd [2];
    logic [15:0] mst [2];
    bit          exp_ready [2];
    logic        act_ready [2];

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    otter_decode_stage #(.XLEN(32), .SUPPORT_MEXT(1'b0), .LOAD_USE_STALL(1'b1)) dut (
        .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready[0]), .ex_ready(ex_ready), .flush(flush), .int_taken(int_taken),
        .ex_valid(ex_valid[0]), .ex_ctrl(ex_ctrl[0]), .ex_pc(ex_pc[0]), .ex_rs1(ex_rs1[0]),
        .ex_rs2(ex_rs2[0]), .ex_rd(ex_rd[0]), .stall_cnt(stall_cnt[0]));

    otter_decode_stage #(.XLEN(32), .SUPPORT_MEXT(1'b1), .LOAD_USE_STALL(1'b0)) dut_alt (
        .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready[1]), .ex_ready(ex_ready), .flush(flush), .int_taken(int_taken),
        .ex_valid(ex_valid[1]), .ex_ctrl(ex_ctrl[1]), .ex_pc(ex_pc[1]), .ex_rs1(ex_rs1[1]),
        .ex_rs2(ex_rs2[1]), .ex_rd(ex_rd[1]), .stall_cnt(stall_cnt[1]));

    // Expected decode, built field by field from the instruction-class rules.
    function automatic void exp_dec(input logic [31:0] ins, input bit m_ok,
                                    output ctrl_t c, output bit u1, output bit u2);
        logic [6:0] op;
        logic [2:0] f3;
        bit ld, st, imm, alu, lui, aui, br, jal, jalr, csr, mret, mul, ill;
        op   = ins[6:0];
        f3   = ins[14:12];
        ld   = (op == 7'h03); st  = (op == 7'h23); imm  = (op == 7'h13);
        alu  = (op == 7'h33); lui = (op == 7'h37); aui  = (op == 7'h17);
        br   = (op == 7'h63); jal = (op == 7'h6F); jalr = (op == 7'h67);
        csr  = (op == 7'h73) && (f3 >= 3'd1) && (f3 <= 3'd3);
        mret = (ins == 32'h3020_0073);
        mul  = alu && (ins[31:25] == 7'h01);
        ill  = !(ld | st | imm | alu | lui | aui | br | jal | jalr | csr | mret) ||
               (br && (f3 == 3'd2 || f3 == 3'd3)) || (mul && !m_ok);
        c = '0;
        c.br_type = br_t'(3'b010);
        c.illegal = ill;
        u1 = 1'b0;
        u2 = 1'b0;
        if (!ill) begin
            if (lui || (csr && f3 == 3'd1))  c.alu_fun = 4'b1001;
            else if (csr && f3 == 3'd2)      c.alu_fun = 4'b0110;
            else if (csr && f3 == 3'd3)      c.alu_fun = 4'b0111;
            else if (alu && !mul)            c.alu_fun = {ins[30], f3};
            else if (imm)                    c.alu_fun = {(f3 == 3'd5) && ins[30], f3};
            if (lui || aui)                  c.alu_srcA = srca_t'(2'd1);
            else if (csr && f3 == 3'd3)      c.alu_srcA = srca_t'(2'd2);
            if (ld || jalr || imm)           c.alu_srcB = srcb_t'(3'd1);
            else if (st)                     c.alu_srcB = srcb_t'(3'd2);
            else if (aui)                    c.alu_srcB = srcb_t'(3'd3);
            else if (csr && f3 != 3'd1)      c.alu_srcB = srcb_t'(3'd4);
            if (imm || alu || lui || aui)    c.rf_wr_sel = wrsel_t'(2'd3);
            else if (ld)                     c.rf_wr_sel = wrsel_t'(2'd2);
            else if (csr)                    c.rf_wr_sel = wrsel_t'(2'd1);
            c.reg_write = (ld | imm | alu | lui | aui | jal | jalr | csr) && (ins[11:7] != 5'd0);
            c.mem_read  = ld;
            c.mem_write = st;
            c.mem_size  = (ld || st) ? f3 : 3'd0;
            if (br) c.br_type = br_t'(f3);
            c.jump    = jump_t'(jal ? 2'd2 : (jalr ? 2'd1 : 2'd0));
            c.csr_op  = csr_op_t'(csr ? f3[1:0] : 2'd0);
            c.mret    = mret;
            c.is_mext = mul;
            c.mext    = mul ? f3 : 3'd0;
            u1 = ld | st | imm | alu | br | jalr | csr;
            u2 = alu | br | st;
        end
    endfunction

    // One clock: record id_ready, advance the model by the stage rules, cross the edge.
    task automatic step();
        ctrl_t dc;
        bit u1, u2, hz;
        #3;
        for (int i = 0; i < 2; i++) begin
            exp_dec(if_instr, sup[i], dc, u1, u2);
            hz = lus[i] && mv[i] && (mc[i].mem_read === 1'b1) && (mrd[i] != 5'd0) &&
                 ((mrd[i] == if_instr[19:15] && u1) || (mrd[i] == if_instr[24:20] && u2));
            exp_ready[i] = !RST && ex_ready && !hz;
            act_ready[i] = id_ready[i];
            if (RST) begin
                mv[i] = 1'b0; mc[i] = '0; mpc[i] = '0; mr1[i] = '0; mr2[i] = '0; mrd[i] = '0; mst[i] = '0;
            end else if (flush) begin
                mv[i] = 1'b0;
            end else if (ex_ready && hz) begin
                mv[i] = 1'b0;
                if (mst[i] != 16'hFFFF) mst[i] = mst[i] + 16'd1;
            end else if (ex_ready && if_valid) begin
                mv[i] = 1'b1;
                mpc[i] = if_pc;
                if (int_taken) begin
                    mc[i] = '0; mc[i].br_type = br_t'(3'b010); mc[i].trap = 1'b1;
                    mr1[i] = '0; mr2[i] = '0; mrd[i] = '0;
                end else begin
                    mc[i] = dc; mr1[i] = if_instr[19:15]; mr2[i] = if_instr[24:20]; mrd[i] = if_instr[11:7];
                end
            end else if (ex_ready) begin
                mv[i] = 1'b0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, d;
        logic [31:0] r;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
        r = $urandom();
        case ($urandom_range(0, 14))
            0:  return {12'd0, a, 3'b010, d, 7'h03};
            1:  return {7'd0, b, a, r[14:12], d, 7'h33};
            2:  return {7'h20, b, a, 3'b000, d, 7'h33};
            3:  return {7'h01, b, a, r[14:12], d, 7'h33};
            4:  return {r[31:20], a, r[14:12], d, 7'h13};
            5:  return {7'h20, r[24:20], a, 3'b101, d, 7'h13};
            6:  return {r[31:12], d, 7'h37};
            7:  return {r[31:12], d, 7'h17};
            8:  return {7'd0, b, a, 3'b010, r[11:7], 7'h23};
            9:  return {7'd0, b, a, r[14:12], 5'd8, 7'h63};
            10: return {r[31:12], d, 7'h6F};
            11: return {r[31:20], a, 3'b000, d, 7'h67};
            12: return {12'h300, a, 3'($urandom_range(1, 3)), d, 7'h73};
            13: return 32'h3020_0073;
            default: return r;
        endcase
    endfunction

    task automatic test_reset();
        RST = 1'b1; if_valid = 1'b1; if_instr = 32'h0050_0093; if_pc = 32'h0;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (ex_valid[i] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, ex_valid[i]); end
            total++; if (act_ready[i] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 0", i, act_ready[i]); end
            total++; if (stall_cnt[i] !== 16'd0) begin bad++; $display("FAIL reset_stall[%0d]: got %0d want 0", i, stall_cnt[i]); end
            total++; if ({ex_ctrl[i], ex_pc[i], ex_rs1[i], ex_rs2[i], ex_rd[i]} !== '0) begin
                bad++; $display("FAIL reset_regs[%0d]: got ctrl=%h pc=%h rd=%0d want zero", i, ex_ctrl[i], ex_pc[i], ex_rd[i]);
            end
        end
        RST = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (ex_valid[i] !== 1'b1 || ex_rd[i] !== 5'd1) begin
                bad++; $display("FAIL first_issue[%0d]: got valid=%b rd=%0d want 1/1", i, ex_valid[i], ex_rd[i]);
            end
        end
    endtask

    task automatic test_straight();
        if_instr = 32'h0050_0093; if_pc = 32'h8;
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (ex_ctrl[i].alu_fun !== 4'b0000 || ex_ctrl[i].alu_srcB !== SRCB_IIMM ||
                         ex_ctrl[i].reg_write !== 1'b1 || ex_valid[i] !== 1'b1) begin
                bad++; $display("FAIL addi[%0d]: got ctrl=%h valid=%b", i, ex_ctrl[i], ex_valid[i]);
            end
            total++; if (ex_ctrl[i] !== mc[i]) begin bad++; $display("FAIL addi_ctrl[%0d]: got %h want %h", i, ex_ctrl[i], mc[i]); end
        end
        if_instr = 32'h0021_01B3; if_pc = 32'hC;
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (ex_ctrl[i].alu_fun !== 4'b0000 || ex_ctrl[i].alu_srcB !== SRCB_RS2 ||
                         ex_rd[i] !== 5'd3 || ex_valid[i] !== 1'b1 || ex_pc[i] !== 32'hC) begin
                bad++; $display("FAIL add[%0d]: got ctrl=%h rd=%0d valid=%b pc=%h", i, ex_ctrl[i], ex_rd[i], ex_valid[i], ex_pc[i]);
            end
        end
    endtask

    task automatic test_load_use();
        if_instr = 32'h0000_A103; if_pc = 32'h10;
        step();
        if_instr = 32'h0021_01B3; if_pc = 32'h14;
        step();
        total++; if (act_ready[0] !== 1'b0) begin bad++; $display("FAIL lu_ready0: got %b want 0", act_ready[0]); end
        total++; if (act_ready[1] !== 1'b1) begin bad++; $display("FAIL lu_ready1: got %b want 1", act_ready[1]); end
        total++; if (ex_valid[0] !== 1'b0 || stall_cnt[0] !== 16'd1) begin
            bad++; $display("FAIL lu_bubble: got valid=%b stall=%0d want 0/1", ex_valid[0], stall_cnt[0]);
        end
        total++; if (ex_valid[1] !== 1'b1 || stall_cnt[1] !== 16'd0 || ex_rd[1] !== 5'd3) begin
            bad++; $display("FAIL lu_nostall: got valid=%b stall=%0d rd=%0d", ex_valid[1], stall_cnt[1], ex_rd[1]);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (act_ready[i] !== 1'b1 || ex_valid[i] !== 1'b1 || ex_rd[i] !== 5'd3 || ex_pc[i] !== 32'h14) begin
                bad++; $display("FAIL lu_issue[%0d]: got ready=%b valid=%b rd=%0d pc=%h", i, act_ready[i], ex_valid[i], ex_rd[i], ex_pc[i]);
            end
            total++; if (stall_cnt[i] !== mst[i]) begin bad++; $display("FAIL lu_stall[%0d]: got %0d want %0d", i, stall_cnt[i], mst[i]); end
        end
    endtask

    task automatic test_backpressure_flush();
        ex_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if_instr = rand_instr(); if_pc = $urandom();
            step();
            for (int i = 0; i < 2; i++) begin
                total++; if (act_ready[i] !== 1'b0 || ex_valid[i] !== 1'b1 || ex_rd[i] !== 5'd3 ||
                             ex_pc[i] !== 32'h14 || ex_ctrl[i] !== mc[i]) begin
                    bad++; $display("FAIL hold[%0d]: got ready=%b valid=%b rd=%0d pc=%h ctrl=%h", i, act_ready[i], ex_valid[i], ex_rd[i], ex_pc[i], ex_ctrl[i]);
                end
            end
        end
        ex_ready = 1'b1; flush = 1'b1; if_instr = 32'h0021_03B3; if_pc = 32'h40;
        step();
        flush = 1'b0; if_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                total++; if (ex_valid[i] !== 1'b0) begin bad++; $display("FAIL flush[%0d]: got valid=%b want 0", i, ex_valid[i]); end
            end
        end
    endtask

    task automatic test_interrupt();
        if_valid = 1'b1; int_taken = 1'b1; if_instr = 32'h0021_01B3; if_pc = 32'h100;
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (ex_valid[i] !== 1'b1 || ex_ctrl[i].trap !== 1'b1 || ex_pc[i] !== 32'h100 ||
                         ex_ctrl[i].reg_write !== 1'b0 || ex_ctrl[i].mem_read !== 1'b0 || ex_ctrl[i].mem_write !== 1'b0) begin
                bad++; $display("FAIL trap[%0d]: got valid=%b ctrl=%h pc=%h", i, ex_valid[i], ex_ctrl[i], ex_pc[i]);
            end
        end
        flush = 1'b1; if_pc = 32'h104;
        step();
        flush = 1'b0; int_taken = 1'b0; if_pc = 32'h108;
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (ex_valid[i] !== 1'b1 || ex_ctrl[i].trap !== 1'b0 || ex_pc[i] !== 32'h108 || ex_rd[i] !== 5'd3) begin
                bad++; $display("FAIL post_flush_trap[%0d]: got valid=%b ctrl=%h pc=%h", i, ex_valid[i], ex_ctrl[i], ex_pc[i]);
            end
        end
    endtask

    task automatic test_mext();
        if_instr = 32'h0220_81B3; if_pc = 32'h200;
        step();
        total++; if (ex_ctrl[0].illegal !== 1'b1 || ex_ctrl[0].reg_write !== 1'b0 || ex_ctrl[0].is_mext !== 1'b0) begin
            bad++; $display("FAIL mul_nomext: got ctrl=%h", ex_ctrl[0]);
        end
        total++; if (ex_ctrl[1].is_mext !== 1'b1 || ex_ctrl[1].mext !== 3'b000 ||
                     ex_ctrl[1].illegal !== 1'b0 || ex_ctrl[1].reg_write !== 1'b1) begin
            bad++; $display("FAIL mul_mext: got ctrl=%h", ex_ctrl[1]);
        end
        if_instr = 32'h0000_2063; if_pc = 32'h204;
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (ex_ctrl[i].illegal !== 1'b1 || ex_ctrl[i].reg_write !== 1'b0) begin
                bad++; $display("FAIL br010[%0d]: got ctrl=%h", i, ex_ctrl[i]);
            end
        end
        if_instr = 32'h0020_8463; if_pc = 32'h208;
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (ex_ctrl[i].illegal !== 1'b0 || ex_ctrl[i].br_type !== BR_EQ || ex_ctrl[i].reg_write !== 1'b0) begin
                bad++; $display("FAIL beq[%0d]: got ctrl=%h", i, ex_ctrl[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if_valid  = ($urandom_range(0, 3) != 0);
            ex_ready  = ($urandom_range(0, 4) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            int_taken = ($urandom_range(0, 19) == 0);
            if_instr  = rand_instr();
            if_pc     = $urandom();
            step();
            for (int i = 0; i < 2; i++) begin
                total++; if (act_ready[i] !== exp_ready[i]) begin bad++; $display("FAIL rnd_ready[%0d] n=%0d: got %b want %b", i, n, act_ready[i], exp_ready[i]); end
                total++; if (ex_valid[i] !== mv[i]) begin bad++; $display("FAIL rnd_valid[%0d] n=%0d: got %b want %b", i, n, ex_valid[i], mv[i]); end
                total++; if (stall_cnt[i] !== mst[i]) begin bad++; $display("FAIL rnd_stall[%0d] n=%0d: got %0d want %0d", i, n, stall_cnt[i], mst[i]); end
                if (mv[i]) begin
                    total++;
                    if ({ex_ctrl[i], ex_pc[i], ex_rs1[i], ex_rs2[i], ex_rd[i]} !== {mc[i], mpc[i], mr1[i], mr2[i], mrd[i]}) begin
                        bad++;
                        $display("FAIL rnd_op[%0d] n=%0d: got ctrl=%h pc=%h rs=%0d,%0d rd=%0d want ctrl=%h pc=%h rs=%0d,%0d rd=%0d",
                                 i, n, ex_ctrl[i], ex_pc[i], ex_rs1[i], ex_rs2[i], ex_rd[i], mc[i], mpc[i], mr1[i], mr2[i], mrd[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; mc[i] = '0; mpc[i] = '0; mr1[i] = '0; mr2[i] = '0; mrd[i] = '0; mst[i] = '0;
        end
        test_reset();
        test_straight();
        test_load_use();
        test_backpressure_flush();
        test_interrupt();
        test_mext();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
